// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the multi-port register file (reg_file_mp).
//   rfState_t     : controller state (RF_INIT sweeps the array, RF_RUN serves
//                   reads and writes)
//   RF_INIT_ZERO  : INIT_MODE value that clears every register
//   RF_INIT_INDEX : INIT_MODE value that loads register i with i
// -----------------------------------------------------------------------------
package reg_file_pkg;

   typedef enum logic {
      RF_INIT = 1'b0,
      RF_RUN  = 1'b1
   } rfState_t;

   localparam int RF_INIT_ZERO  = 0;
   localparam int RF_INIT_INDEX = 1;

endpackage

// File: rtl/reg_file_rd_mux.sv
// -----------------------------------------------------------------------------
// reg_file_rd_mux
// Output stage of one read port of reg_file_mp.
// Build option: macro REG_FILE_MP_BYPASS_EN adds the same-cycle write bypass
// (and its ports); without it the lane returns the stored value only.
// Ports:
//   ready      in   register file is in RUN; lane reads 0 otherwise
//   rdAddr     in   [ADDR_W] address of this lane; address 0 always reads 0
//   storedData in   [DATA_W] array content at rdAddr (pre-write value)
//   wr0Go/wr0Addr/wr0Data, wr1Go/wr1Addr/wr1Data
//              in   qualified write ports (bypass build only); a *Go flag is
//                   already gated by ready and a non-zero address
//   rdData     out  [DATA_W] lane result
// -----------------------------------------------------------------------------
module reg_file_rd_mux #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              ready,
   input  logic [ADDR_W-1:0] rdAddr,
   input  logic [DATA_W-1:0] storedData,
`ifdef REG_FILE_MP_BYPASS_EN
   input  logic              wr0Go,
   input  logic [ADDR_W-1:0] wr0Addr,
   input  logic [DATA_W-1:0] wr0Data,
   input  logic              wr1Go,
   input  logic [ADDR_W-1:0] wr1Addr,
   input  logic [DATA_W-1:0] wr1Data,
`endif
   output logic [DATA_W-1:0] rdData
);

   // NOTE: rdData gets a value before any if, so every path assigns it and no latch is inferred.
   always_comb begin
      rdData = storedData;
`ifdef REG_FILE_MP_BYPASS_EN
      // Port 1 is checked first: it is also the port whose write lands.
      if (wr1Go && (wr1Addr == rdAddr)) begin
         rdData = wr1Data;
      end else if (wr0Go && (wr0Addr == rdAddr)) begin
         rdData = wr0Data;
      end
`endif
      // Register 0 is hard zero and is never written, so its storage is
      // don't-care; masking last also hides undefined contents before RUN.
      if (!ready || (rdAddr == '0)) begin
         rdData = '0;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
// NUM_REGS x DATA_W register file with NUM_RD combinational read ports and two
// write ports. After reset an INIT sweep writes registers 1..NUM_REGS-1 (one
// per cycle, value 0 or the register index depending on INIT_MODE); ready
// then rises and writes are accepted. Register 0 always reads 0.
// Build option: macro REG_FILE_MP_BYPASS_EN forwards a same-cycle write to a
// matching read (port 1 over port 0); undefined, reads see the stored value.
// Ports:
//   clk                       in   clock, rising edge
//   rst                       in   synchronous active-high reset, restarts INIT
//   rd_addr                   in   [NUM_RD*ADDR_W] lane k at [k*ADDR_W +: ADDR_W]
//   rd_data                   out  [NUM_RD*DATA_W] lane k at [k*DATA_W +: DATA_W]
//   wr0_en/wr0_addr/wr0_data  in   write port 0
//   wr1_en/wr1_addr/wr1_data  in   write port 1 (wins on equal addresses)
//   ready                     out  INIT finished and not in reset
//   wr_collide                out  one-cycle pulse after both ports wrote the
//                                  same non-zero address
// -----------------------------------------------------------------------------
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter  int DATA_W    = 32,
   parameter  int NUM_REGS  = 32,
   parameter  int NUM_RD    = 2,
   parameter  int INIT_MODE = RF_INIT_ZERO,
   localparam int ADDR_W    = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   output logic                     ready,
   output logic                     wr_collide
);

   rfState_t          state;
   rfState_t          nextState;
   logic [ADDR_W-1:0] initIdx;
   logic [DATA_W-1:0] initValue;
   logic              lastIdx;
   logic              wr0Go;
   logic              wr1Go;
   logic              collideQ;
   logic [DATA_W-1:0] regs [NUM_REGS];

   // ---------------------------------------------------------------- control
   assign lastIdx = (initIdx == ADDR_W'(NUM_REGS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RF_INIT;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         RF_INIT: if (lastIdx) nextState = RF_RUN;
         RF_RUN:  nextState = RF_RUN;
         default: nextState = RF_INIT;
      endcase
   end

   // Index 0 is skipped: register 0 is masked at the read side instead.
   always_ff @(posedge clk) begin
      if (rst) begin
         initIdx <= ADDR_W'(1);
      end else if (state == RF_INIT) begin
         initIdx <= initIdx + ADDR_W'(1);
      end
   end

   // rst also gates ready combinationally so the first reset cycle already
   // blocks writes and blanks reads, even though state is still RF_RUN.
   assign ready = (state == RF_RUN) && !rst;

   assign wr0Go = ready && wr0_en && (wr0_addr != '0);
   assign wr1Go = ready && wr1_en && (wr1_addr != '0);

   assign initValue = (INIT_MODE == RF_INIT_INDEX) ? DATA_W'(initIdx) : '0;

   // ---------------------------------------------------------------- storage
   // NOTE: the array has no reset term; the INIT sweep defines it, which keeps it a plain memory without a reset net per bit.
   // NOTE: non-blocking writes all see pre-edge values; on equal addresses the later port-1 assignment is the one that lands.
   always_ff @(posedge clk) begin
      if (!rst && (state == RF_INIT)) begin
         regs[initIdx] <= initValue;
      end else begin
         if (wr0Go) regs[wr0_addr] <= wr0_data;
         if (wr1Go) regs[wr1_addr] <= wr1_data;
      end
   end

   // -------------------------------------------------------------- collision
   always_ff @(posedge clk) begin
      if (rst) begin
         collideQ <= 1'b0;
      end else begin
         collideQ <= wr0Go && wr1Go && (wr0_addr == wr1_addr);
      end
   end

   assign wr_collide = collideQ && !rst;

   // ------------------------------------------------------------- read lanes
   for (genvar k = 0; k < NUM_RD; k++) begin : gRd
      logic [ADDR_W-1:0] laneAddr;

      assign laneAddr = rd_addr[k*ADDR_W +: ADDR_W];

      reg_file_rd_mux #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) uRdMux (
         .ready      (ready),
         .rdAddr     (laneAddr),
         .storedData (regs[laneAddr]),
`ifdef REG_FILE_MP_BYPASS_EN
         .wr0Go      (wr0Go),
         .wr0Addr    (wr0_addr),
         .wr0Data    (wr0_data),
         .wr1Go      (wr1Go),
         .wr1Addr    (wr1_addr),
         .wr1Data    (wr1_data),
`endif
         .rdData     (rd_data[k*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_reg_file_mp
// Two instances: dutA (32 x 32 bit, 2 read ports, INIT_MODE = index) and
// dutB (8 x 16 bit, 4 read ports, INIT_MODE = zero). A stimulus task drives
// one instance per cycle, predicts that cycle's outputs from an array model
// and pushes them to a scoreboard; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_file_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ------------------------------------------------------------------ dutA
   logic        rstA;
   logic [9:0]  rdAddrA;
   logic [63:0] rdDataA;
   logic        wr0EnA, wr1EnA;
   logic [4:0]  wr0AddrA, wr1AddrA;
   logic [31:0] wr0DataA, wr1DataA;
   logic        readyA, colA;

   reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .INIT_MODE(1)) dutA (
      .clk(clk), .rst(rstA), .rd_addr(rdAddrA), .rd_data(rdDataA),
      .wr0_en(wr0EnA), .wr0_addr(wr0AddrA), .wr0_data(wr0DataA),
      .wr1_en(wr1EnA), .wr1_addr(wr1AddrA), .wr1_data(wr1DataA),
      .ready(readyA), .wr_collide(colA)
   );

   // ------------------------------------------------------------------ dutB
   logic        rstB;
   logic [11:0] rdAddrB;
   logic [63:0] rdDataB;
   logic        wr0EnB, wr1EnB;
   logic [2:0]  wr0AddrB, wr1AddrB;
   logic [15:0] wr0DataB, wr1DataB;
   logic        readyB, colB;

   reg_file_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(4), .INIT_MODE(0)) dutB (
      .clk(clk), .rst(rstB), .rd_addr(rdAddrB), .rd_data(rdDataB),
      .wr0_en(wr0EnB), .wr0_addr(wr0AddrB), .wr0_data(wr0DataB),
      .wr1_en(wr1EnB), .wr1_addr(wr1AddrB), .wr1_data(wr1DataB),
      .ready(readyB), .wr_collide(colB)
   );

   // ------------------------------------------------------------ bench types
   typedef struct {
      bit               rst;
      logic [3:0][7:0]  ra;
      bit               w0e;
      logic [7:0]       w0a;
      logic [31:0]      w0d;
      bit               w1e;
      logic [7:0]       w1a;
      logic [31:0]      w1d;
   } stim_t;

   typedef struct {
      int               cyc;
      int               dut;
      string            name;
      logic             rdy;
      logic             col;
      int               nrd;
      logic [3:0][31:0] rd;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [2][32];
   int          since [2];
   bit          prevCol [2];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", what, act, exp, cyc);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s.rst = 1'b0;
      s.ra  = '0;
      s.w0e = 1'b0; s.w0a = '0; s.w0d = '0;
      s.w1e = 1'b0; s.w1a = '0; s.w1d = '0;
      return s;
   endfunction

   function automatic stim_t rnd(input int maxA);
      stim_t s;
      s = idle();
      for (int k = 0; k < 4; k++) s.ra[k] = 8'($urandom_range(0, maxA));
      s.w0e = 1'($urandom_range(0, 1));
      s.w0a = 8'($urandom_range(0, maxA));
      s.w0d = $urandom();
      s.w1e = 1'($urandom_range(0, 1));
      s.w1a = 8'($urandom_range(0, maxA));
      s.w1d = $urandom();
      return s;
   endfunction

   // One clock cycle on instance d: drive, predict, push, update the model.
   task automatic step(input int d, input stim_t s, input string name);
      int          nr   = (d == 0) ? 32 : 8;
      int          nrd  = (d == 0) ? 2 : 4;
      logic [31:0] msk  = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      int          a0   = int'(s.w0a) % nr;
      int          a1   = int'(s.w1a) % nr;
      int          ra;
      bit          rdy;
      logic [31:0] val;
      exp_t        e;

      @(posedge clk);
      #1;
      if (d == 0) begin
         rstA = s.rst;
         for (int k = 0; k < 2; k++) rdAddrA[k*5 +: 5] = s.ra[k][4:0];
         wr0EnA = s.w0e; wr0AddrA = s.w0a[4:0]; wr0DataA = s.w0d;
         wr1EnA = s.w1e; wr1AddrA = s.w1a[4:0]; wr1DataA = s.w1d;
      end else begin
         rstB = s.rst;
         for (int k = 0; k < 4; k++) rdAddrB[k*3 +: 3] = s.ra[k][2:0];
         wr0EnB = s.w0e; wr0AddrB = s.w0a[2:0]; wr0DataB = s.w0d[15:0];
         wr1EnB = s.w1e; wr1AddrB = s.w1a[2:0]; wr1DataB = s.w1d[15:0];
      end

      // Contents are only observable after INIT, so load the post-INIT
      // image whenever reset is seen; writes before ready never apply.
      if (s.rst) begin
         rdy      = 1'b0;
         since[d] = 0;
         for (int i = 0; i < nr; i++) mdl[d][i] = (d == 0) ? 32'(i) : 32'h0;
      end else begin
         rdy = (since[d] >= nr - 1);
      end

      e.cyc  = cyc;
      e.dut  = d;
      e.name = name;
      e.rdy  = rdy;
      e.col  = prevCol[d] && !s.rst;
      e.nrd  = nrd;
      e.rd   = '0;
      for (int k = 0; k < nrd; k++) begin
         ra  = int'(s.ra[k]) % nr;
         val = 32'h0;
         if (rdy && ra != 0) begin
            val = mdl[d][ra];
`ifdef REG_FILE_MP_BYPASS_EN
            if (s.w1e && a1 == ra)      val = s.w1d & msk;
            else if (s.w0e && a0 == ra) val = s.w0d & msk;
`endif
         end
         e.rd[k] = val;
      end
      sb.push_back(e);

      prevCol[d] = rdy && s.w0e && s.w1e && (a0 == a1) && (a0 != 0);
      if (rdy) begin
         if (s.w0e && a0 != 0) mdl[d][a0] = s.w0d & msk;
         if (s.w1e && a1 != 0) mdl[d][a1] = s.w1d & msk;
      end
      if (!s.rst) since[d]++;
   endtask

   // --------------------------------------------------------------- monitor
   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [31:0] act;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.cyc != cyc) check({e.name, "_late"}, e.cyc, cyc);
         check({e.name, "_ready"}, (e.dut == 0) ? readyA : readyB, e.rdy);
         check({e.name, "_collide"}, (e.dut == 0) ? colA : colB, e.col);
         for (int k = 0; k < e.nrd; k++) begin
            act = (e.dut == 0) ? rdDataA[k*32 +: 32] : {16'h0, rdDataB[k*16 +: 16]};
            check($sformatf("%s_lane%0d", e.name, k), act, e.rd[k]);
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   // -------------------------------------------------------------- stimulus
   initial begin : stimulus
      stim_t s;
      rstA = 1'b1; rdAddrA = '0; wr0EnA = 1'b0; wr1EnA = 1'b0;
      wr0AddrA = '0; wr1AddrA = '0; wr0DataA = '0; wr1DataA = '0;
      rstB = 1'b1; rdAddrB = '0; wr0EnB = 1'b0; wr1EnB = 1'b0;
      wr0AddrB = '0; wr1AddrB = '0; wr0DataB = '0; wr1DataB = '0;

      // dutA: reset, then 31 INIT cycles with ignored write attempts
      s = idle(); s.rst = 1'b1;
      repeat (2) step(0, s, "a_rst");
      for (int i = 0; i < 31; i++) begin
         s = rnd(31); s.ra[0] = 8'd5; s.ra[1] = 8'd0;
         step(0, s, "a_init");
      end
      s = idle(); s.ra[0] = 8'd5; s.ra[1] = 8'd0;
      step(0, s, "a_first_ready");

      // write then read back, same cycle and next cycle
      s = idle(); s.w0e = 1'b1; s.w0a = 8'd3; s.w0d = 32'hDEAD_BEEF; s.ra[0] = 8'd3;
      step(0, s, "a_wr3_same");
      s = idle(); s.ra[0] = 8'd3;
      step(0, s, "a_wr3_next");

      // same-address write from both ports
      s = idle(); s.w0e = 1'b1; s.w0a = 8'd7; s.w0d = 32'h11;
      s.w1e = 1'b1; s.w1a = 8'd7; s.w1d = 32'h22; s.ra[0] = 8'd7;
      step(0, s, "a_coll_wr");
      s = idle(); s.ra[0] = 8'd7;
      step(0, s, "a_coll_pulse");
      step(0, s, "a_coll_clear");

      // both ports target register 0
      s = idle(); s.w0e = 1'b1; s.w0a = 8'd0; s.w0d = 32'hFFFF_FFFF;
      s.w1e = 1'b1; s.w1a = 8'd0; s.w1d = 32'h1;
      step(0, s, "a_zero_wr");
      s = idle();
      step(0, s, "a_zero_next");
      step(0, s, "a_zero_clear");

      // random traffic on a narrow address window to provoke collisions
      for (int i = 0; i < 200; i++) step(0, rnd(7), "a_rand_narrow");
      for (int i = 0; i < 100; i++) step(0, rnd(31), "a_rand_wide");

      // reset, then pulse reset again when INIT has reached index 10
      s = idle(); s.rst = 1'b1;
      step(0, s, "a_rst2");
      for (int i = 0; i < 9; i++) step(0, rnd(31), "a_init2");
      s = idle(); s.rst = 1'b1;
      step(0, s, "a_midrst");
      for (int i = 0; i < 31; i++) step(0, rnd(31), "a_reinit");
      for (int i = 0; i < 16; i++) begin
         s = idle(); s.ra[0] = 8'(2 * i); s.ra[1] = 8'(2 * i + 1);
         step(0, s, "a_sweep");
      end

      // dutB: reset, 7 INIT cycles, four independent lanes
      s = idle(); s.rst = 1'b1;
      repeat (2) step(1, s, "b_rst");
      for (int i = 0; i < 7; i++) step(1, rnd(7), "b_init");
      s = idle(); s.ra = {8'd7, 8'd6, 8'd2, 8'd1};
      step(1, s, "b_first_ready");
      s = idle(); s.w0e = 1'b1; s.w0a = 8'd1; s.w0d = 32'hABCD_1111;
      s.w1e = 1'b1; s.w1a = 8'd2; s.w1d = 32'h2222;
      step(1, s, "b_wr12");
      s = idle(); s.w0e = 1'b1; s.w0a = 8'd6; s.w0d = 32'h6666;
      s.w1e = 1'b1; s.w1a = 8'd7; s.w1d = 32'h5A5A_7777;
      step(1, s, "b_wr67");
      s = idle(); s.ra = {8'd7, 8'd6, 8'd2, 8'd1};
      step(1, s, "b_read4");
      s = idle(); s.ra = {8'd1, 8'd7, 8'd7, 8'd0};
      step(1, s, "b_read_dup");
      for (int i = 0; i < 200; i++) step(1, rnd(7), "b_rand");

      repeat (2) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL provide parameter DATA_W, 32, register width in bits.
REQ-002 SHALL provide parameter NUM_REGS, 32, register count (power of two, >= 4); ADDR_W = log2(NUM_REGS).
REQ-003 SHALL provide parameter NUM_RD, 2, number of independent read ports (1..4).
REQ-004 SHALL provide parameter INIT_MODE, 0, init value: 0 = all zero, 1 = register index (reg i = i).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 rd_data  output  NUM_RD*DATA_W  packed read data, combinational from rd_addr.
REQ-009 wr0_en / wr0_addr / wr0_data  input  1 / ADDR_W / DATA_W  write port 0.
REQ-010 wr1_en / wr1_addr / wr1_data  input  1 / ADDR_W / DATA_W  write port 1.
REQ-011 ready  output  1  high when init done and writes are accepted.
REQ-012 wr_collide  output  1  registered one-cycle pulse: both ports wrote the same non-zero address.

Function
REQ-013 FSM states INIT and RUN; rst forces INIT with init_idx = 1.
REQ-014 INIT: one register per cycle, reg[init_idx] <= INIT_MODE ? init_idx : 0; init_idx increments.
REQ-015 INIT -> RUN on the cycle init_idx = NUM_REGS-1 is written; ready rises the next cycle; init takes NUM_REGS-1 cycles.
REQ-016 While ready = 0: wr0_en/wr1_en ignored, every rd_data lane reads 0, wr_collide = 0.
REQ-017 Register 0 SHALL always read 0; writes to address 0 dropped on either port.
REQ-018 RUN: enabled write port updates reg[addr] on the rising edge; new value visible the next cycle (latency 1).
REQ-019 Both ports enabled, same address: port 1 data wins; wr_collide pulses the next cycle if address != 0.
REQ-020 Both ports enabled, different addresses: both writes take effect the same cycle.
REQ-021 Read ports independent; any number may address the same register.
REQ-022 rst asserted during INIT or RUN SHALL restart INIT from index 1; no partial state kept.

Reset
REQ-023 During rst: ready = 0, wr_collide = 0, FSM = INIT, init_idx = 1.
REQ-024 Register contents are defined only after INIT completes; reg 0 reads 0 regardless.

Configuration
REQ-025 Macro REG_FILE_MP_BYPASS_EN defined: in RUN, a read whose address matches an enabled same-cycle write (non-zero address) returns that write data, port 1 over port 0.
REQ-026 Macro undefined: reads return the stored (pre-write) value; no bypass muxes synthesised.

Structure
REQ-027 Shared package reg_file_pkg holds the FSM state enum (RF_INIT, RF_RUN) and INIT_MODE constants (RF_INIT_ZERO = 0, RF_INIT_INDEX = 1).
REQ-028 Sub-module reg_file_rd_mux (one per read port) does zero-register masking, not-ready masking, and optional bypass select.

Verification
REQ-029 Reset, INIT_MODE=1, NUM_REGS=32 -> ready low 31 cycles then high; rd_addr=5 reads 0x5; rd_addr=0 reads 0.
REQ-030 RUN, wr0 addr 3 data 0xDEADBEEF -> next cycle reads 0xDEADBEEF; same cycle reads 0xDEADBEEF with BYPASS_EN, old value without.
REQ-031 wr0 addr 7 data 0x11, wr1 addr 7 data 0x22 same cycle -> reg 7 = 0x22, wr_collide high exactly one cycle.
REQ-032 wr0 addr 0 data 0xFFFFFFFF, wr1 addr 0 data 0x1 -> reg 0 reads 0, wr_collide stays 0.
REQ-033 rst pulsed mid-INIT at idx 10 -> INIT restarts at 1, ready rises 31 cycles after rst release; writes issued during INIT have no effect.
REQ-034 NUM_RD=4, DATA_W=16, NUM_REGS=8, INIT_MODE=0 -> all four ports read correct independent values after writes to regs 1,2,6,7; init takes 7 cycles.
